// File: rtl/multi_pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: channel state
// encoding, power-up configuration and the start-time legality rule.
package multi_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_e;

  localparam int DEF_DELAY  = 0;
  localparam int DEF_WIDTH  = 1;
  localparam int DEF_PERIOD = 2;
  localparam int DEF_BURST  = 1;

  // A run needs at least one high cycle and at least one low cycle per period.
  function automatic logic cfg_legal(input logic [63:0] width, input logic [63:0] period);
    return (width != 64'd0) && (period > width);
  endfunction

endpackage

// File: rtl/multi_pulse_gen_ch.sv
// One pulse-generator channel: programmable config, working copy latched at
// start, IDLE/DELAY/HIGH/LOW sequencer and the cycle/burst counters.
module pulse_gen_ch
  import multi_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_cfg_we,
  input  logic [CNT_W-1:0]   i_cfg_delay,
  input  logic [CNT_W-1:0]   i_cfg_width,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_pulse,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  logic [CNT_W-1:0]   cfg_delay, cfg_width, cfg_period;
  logic [BURST_W-1:0] cfg_burst;
  logic [CNT_W-1:0]   wk_width, wk_period, cnt;
  logic [BURST_W-1:0] wk_burst, burst_cnt;
  ch_state_e          state;

  logic abort, start_go, legal, cnt_zero, last_pulse;

  assign abort      = (state != ST_IDLE) && (!i_en || i_stop);
  assign start_go   = (state == ST_IDLE) && i_start && i_en && !i_stop;
  assign legal      = cfg_legal(64'(cfg_width), 64'(cfg_period));
  assign cnt_zero   = (cnt == '0);
  assign last_pulse = (wk_burst != '0) && (burst_cnt == wk_burst - BURST_W'(1));
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_delay  <= CNT_W'(DEF_DELAY);
      cfg_width  <= CNT_W'(DEF_WIDTH);
      cfg_period <= CNT_W'(DEF_PERIOD);
      cfg_burst  <= BURST_W'(DEF_BURST);
    end else if (i_cfg_we) begin
      cfg_delay  <= i_cfg_delay;
      cfg_width  <= i_cfg_width;
      cfg_period <= i_cfg_period;
      cfg_burst  <= i_cfg_burst;
    end
  end

  // Working copies and counters are only meaningful outside IDLE, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (start_go && legal) begin
      wk_width  <= cfg_width;
      wk_period <= cfg_period;
      wk_burst  <= cfg_burst;
      cnt       <= cfg_delay;
      burst_cnt <= '0;
    end else if (!abort) begin
      case (state)
        ST_DELAY, ST_LOW: cnt <= cnt_zero ? wk_width - CNT_W'(1) : cnt - CNT_W'(1);
        ST_HIGH: begin
          if (cnt_zero) begin
            cnt <= wk_period - wk_width - CNT_W'(1);
            if (wk_burst != '0 && burst_cnt != '1) burst_cnt <= burst_cnt + BURST_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_pulse <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        o_pulse <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_go) begin
              if (legal) state <= ST_DELAY;
              else       o_err <= 1'b1;
            end
          end
          ST_DELAY, ST_LOW: begin
            if (cnt_zero) begin
              state   <= ST_HIGH;
              o_pulse <= 1'b1;
            end
          end
          ST_HIGH: begin
            if (cnt_zero) begin
              o_pulse <= 1'b0;
              // The final pulse of a finite burst returns straight to IDLE.
              if (last_pulse) begin
                state  <= ST_IDLE;
                o_done <= 1'b1;
              end else begin
                state <= ST_LOW;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_pulse_gen.sv
// N-channel programmable pulse generator: routes config writes to the
// addressed channel and replicates the per-channel engine.
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16,
  parameter int CH_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_cfg_we,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [CNT_W-1:0]   i_cfg_delay,
  input  logic [CNT_W-1:0]   i_cfg_width,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic [N_CH-1:0]    i_start,
  input  logic [N_CH-1:0]    i_stop,
  output logic [N_CH-1:0]    o_pulse,
  output logic [N_CH-1:0]    o_busy,
  output logic [N_CH-1:0]    o_done,
  output logic [N_CH-1:0]    o_err
);

  logic [N_CH-1:0] ch_we;

  // Writes addressed beyond N_CH-1 match no channel and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_we[i] = i_cfg_we && (i_cfg_ch == CH_W'(i));

    pulse_gen_ch #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en),
      .i_cfg_we     (ch_we[i]),
      .i_cfg_delay  (i_cfg_delay),
      .i_cfg_width  (i_cfg_width),
      .i_cfg_period (i_cfg_period),
      .i_cfg_burst  (i_cfg_burst),
      .i_start      (i_start[i]),
      .i_stop       (i_stop[i]),
      .o_pulse      (o_pulse[i]),
      .o_busy       (o_busy[i]),
      .o_done       (o_done[i]),
      .o_err        (o_err[i])
    );
  end

endmodule
